// File: rtl/y86_pkg.sv
// Shared y86-64 encodings (icode, ifun, stat, register IDs) and helpers used by
// the fetch, decode, execute and memory stages.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;
  localparam logic [3:0] S_BUB = 4'h8;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  // True for statuses that must freeze architectural condition-code updates.
  function automatic logic stat_is_exc(input logic [3:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                     input logic sf, input logic of);
    logic c;
    case (ifun)
      4'h0:    c = 1'b1;
      4'h1:    c = (sf ^ of) | zf;
      4'h2:    c = sf ^ of;
      4'h3:    c = zf;
      4'h4:    c = ~zf;
      4'h5:    c = ~(sf ^ of);
      4'h6:    c = ~(sf ^ of) & ~zf;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// E-register inputs, pipeline status/control inputs, forwarding outputs and the
// M-register outputs of the execute stage.
interface execute_stage_if;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  m_stat, W_stat;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;

  modport master (
    output E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_valC, E_valA, E_valB,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_dstE, e_Cnd,
    input  M_stat, M_icode, M_dstE, M_dstM, M_Cnd, M_valE, M_valA
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_valC, E_valA, E_valB,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_dstE, e_Cnd,
    output M_stat, M_icode, M_dstE, M_dstM, M_Cnd, M_valE, M_valA
  );
endinterface

// File: rtl/y86_alu.sv
// Combinational 64-bit y86 ALU: result = B op A, with ZF/SF/OF flags.
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] i_alu_a,
  input  logic [63:0] i_alu_b,
  input  alu_fn_e     i_alu_fun,
  output logic [63:0] o_result,
  output logic        o_zf,
  output logic        o_sf,
  output logic        o_of
);

  // Operation select and signed-overflow detection.
  always_comb begin
    o_result = 64'd0;
    o_of     = 1'b0;
    case (i_alu_fun)
      ALU_ADD: begin
        o_result = i_alu_b + i_alu_a;
        o_of     = (i_alu_a[63] == i_alu_b[63]) && (o_result[63] != i_alu_a[63]);
      end
      ALU_SUB: begin
        o_result = i_alu_b - i_alu_a;
        o_of     = (i_alu_a[63] != i_alu_b[63]) && (o_result[63] != i_alu_b[63]);
      end
      ALU_AND: begin
        o_result = i_alu_b & i_alu_a;
        o_of     = 1'b0;
      end
      ALU_XOR: begin
        o_result = i_alu_b ^ i_alu_a;
        o_of     = 1'b0;
      end
      default: begin
        o_result = i_alu_b + i_alu_a;
        o_of     = 1'b0;
      end
    endcase
  end

  assign o_zf = (o_result == 64'd0);
  assign o_sf = o_result[63];

endmodule

// File: rtl/execute_stage.sv
// y86-64 execute stage: ALU, condition codes, cmov squash and the M register.
// Optional feature macro: EXEC_IADDQ_EN (iaddq executes and sets CC).
module execute_stage
  import y86_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  execute_stage_if.slave bus
);

  logic [63:0] w_alu_a, w_alu_b, w_alu_res;
  alu_fn_e     w_alu_fun;
  logic        w_zf, w_sf, w_of;
  logic        w_cc_op, w_set_cc, w_cnd;
  logic [3:0]  w_dst_e;
  logic        r_zf, r_sf, r_of;
  logic [3:0]  r_m_stat, r_m_icode, r_m_dste, r_m_dstm;
  logic        r_m_cnd;
  logic [63:0] r_m_vale, r_m_vala;

  // ALU A operand: register, constant or stack-pointer step.
  always_comb begin
    w_alu_a = 64'd0;
    case (bus.E_icode)
      I_RRMOVQ, I_OPQ:              w_alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = bus.E_valC;
`ifdef EXEC_IADDQ_EN
      I_IADDQ:                      w_alu_a = bus.E_valC;
`endif
      I_CALL, I_PUSHQ:              w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:                w_alu_a = 64'd8;
      default:                      w_alu_a = 64'd0;
    endcase
  end

  // ALU B operand: valB for address/stack/arith instructions.
  always_comb begin
    w_alu_b = 64'd0;
    case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alu_b = bus.E_valB;
`ifdef EXEC_IADDQ_EN
      I_IADDQ:  w_alu_b = bus.E_valB;
`endif
      default:  w_alu_b = 64'd0;
    endcase
  end

  // Only OPq selects a non-add function; unknown ifun values fall back to add.
  always_comb begin
    w_alu_fun = ALU_ADD;
    w_cc_op   = 1'b0;
    if (bus.E_icode == I_OPQ) begin
      w_cc_op = 1'b1;
      case (bus.E_ifun)
        4'h0:    w_alu_fun = ALU_ADD;
        4'h1:    w_alu_fun = ALU_SUB;
        4'h2:    w_alu_fun = ALU_AND;
        4'h3:    w_alu_fun = ALU_XOR;
        default: w_alu_fun = ALU_ADD;
      endcase
`ifdef EXEC_IADDQ_EN
    end else if (bus.E_icode == I_IADDQ) begin
      w_cc_op   = 1'b1;
      w_alu_fun = ALU_ADD;
`endif
    end else begin
      w_cc_op   = 1'b0;
      w_alu_fun = ALU_ADD;
    end
  end

  y86_alu u_alu (
    .i_alu_a   (w_alu_a),
    .i_alu_b   (w_alu_b),
    .i_alu_fun (w_alu_fun),
    .o_result  (w_alu_res),
    .o_zf      (w_zf),
    .o_sf      (w_sf),
    .o_of      (w_of)
  );

  assign w_set_cc = w_cc_op && !stat_is_exc(bus.m_stat) && !stat_is_exc(bus.W_stat);
  assign w_cnd    = cond_eval(bus.E_ifun, r_zf, r_sf, r_of);

  // A cmov whose condition fails writes nowhere.
  always_comb begin
    w_dst_e = bus.E_dstE;
    if ((bus.E_icode == I_RRMOVQ) && !w_cnd) begin
      w_dst_e = RNONE;
    end else begin
      w_dst_e = bus.E_dstE;
    end
  end

  // Condition-code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= w_zf;
      r_sf <= w_sf;
      r_of <= w_of;
    end
  end

  // M pipeline register: loads every edge, bubble overrides the E contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_stat  <= S_BUB;
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_vale  <= 64'd0;
      r_m_vala  <= 64'd0;
      r_m_dste  <= RNONE;
      r_m_dstm  <= RNONE;
    end else if (bus.M_bubble) begin
      r_m_stat  <= S_BUB;
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_vale  <= 64'd0;
      r_m_vala  <= 64'd0;
      r_m_dste  <= RNONE;
      r_m_dstm  <= RNONE;
    end else begin
      r_m_stat  <= bus.E_stat;
      r_m_icode <= bus.E_icode;
      r_m_cnd   <= w_cnd;
      r_m_vale  <= w_alu_res;
      r_m_vala  <= bus.E_valA;
      r_m_dste  <= w_dst_e;
      r_m_dstm  <= bus.E_dstM;
    end
  end

  assign bus.e_valE  = w_alu_res;
  assign bus.e_dstE  = w_dst_e;
  assign bus.e_Cnd   = w_cnd;
  assign bus.M_stat  = r_m_stat;
  assign bus.M_icode = r_m_icode;
  assign bus.M_Cnd   = r_m_cnd;
  assign bus.M_valE  = r_m_vale;
  assign bus.M_valA  = r_m_vala;
  assign bus.M_dstE  = r_m_dste;
  assign bus.M_dstM  = r_m_dstm;

endmodule
